// File: rtl/uart_pkg.sv
// uart_pkg: constants and state encoding shared by the UART transmit and
// receive controllers.
//   OSR_13 / OSR_16 : oversample ratios selectable through osm_sel
//   DATA_W_DEF      : default number of data bits per frame
//   uart_state_e    : frame sequencing states
//   osr_last()      : terminal tick count for the selected ratio
package uart_pkg;

    localparam int OSR_13     = 13;
    localparam int OSR_16     = 16;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ALIGN  = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } uart_state_e;

    // Value of the tick counter on the last tick of a bit.
    function automatic logic [4:0] osr_last(input logic osm);
        return osm ? 5'(OSR_16 - 1) : 5'(OSR_13 - 1);
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: requester-side handshake bundle of the shared UART
// transmitter.
//   req     : per-requester level request
//   data_in : requester i byte at [i*DATA_W +: DATA_W]
//   gnt     : one-hot single-cycle pulse, byte captured
//   done    : one-hot single-cycle pulse, stop bit finished
//   busy    : high from grant until the cycle done pulses
// master = requester side, slave = scheduler side.
interface uart_tx_sched_if #(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 8
) ();

    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] data_in;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        done;
    logic                    busy;

    modport master (
        output req,
        output data_in,
        input  gnt,
        input  done,
        input  busy
    );

    modport slave (
        input  req,
        input  data_in,
        output gnt,
        output done,
        output busy
    );

endinterface

// File: rtl/uart_tx_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   en      : arbitration allowed this cycle
//   req     : request vector
//   ptr     : index with highest priority this round
//   gnt     : one-hot winner (zero when en is low or no request)
//   ptr_nxt : index following the winner, wrapping at N_REQ
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [PTR_W-1:0] ptr_nxt
);

    logic found;
    int   idx;

    always_comb begin
        gnt     = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                ptr_nxt  = (idx == N_REQ - 1) ? '0 : PTR_W'(idx + 1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: one UART transmit serializer shared round-robin between
// N_REQ byte sources. Sends 8N1 frames (8E1 when UART_TX_PARITY_EN is
// defined) with bit timing derived from rising edges of tx_clk.
// Ports:
//   m_clk   : system clock
//   reset   : synchronous, active-low
//   osm_sel : 0 = 13 ticks/bit, 1 = 16 ticks/bit, latched at grant
//   tx_clk  : oversample clock, already m_clk-synchronous
//   bus     : requester handshake (req, data_in, gnt, done, busy)
//   txd     : serial output, idle high
// Build option: UART_TX_PARITY_EN adds an even-parity bit before stop.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | txd high, arbitrate among requesters
// ALIGN  | byte captured, waiting for a tick to start the start bit
// START  | start bit (low) for OSR ticks
// DATA   | DATA_W data bits, LSB first, OSR ticks each
// PARITY | even parity bit, OSR ticks (only with UART_TX_PARITY_EN)
// STOP   | stop bit (high) for OSR ticks, done on its last tick
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  m_clk,
    input  logic                  reset,
    input  logic                  osm_sel,
    input  logic                  tx_clk,
    uart_tx_sched_if.slave        bus,
    output logic                  txd
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_ALIGN  = ST_ALIGN;
    localparam logic [2:0] S_START  = ST_START;
    localparam logic [2:0] S_DATA   = ST_DATA;
    localparam logic [2:0] S_PARITY = ST_PARITY;
    localparam logic [2:0] S_STOP   = ST_STOP;

    logic              tx_clk_q;
    logic [2:0]        state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [N_REQ-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              osm_q, osm_d;
    logic [4:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              txd_q, txd_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic              busy_q, busy_d;

    logic              tick;
    logic              bit_end;
    logic              in_frame;
    logic [N_REQ-1:0]  arb_gnt;
    logic [PTR_W-1:0]  arb_ptr_nxt;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .en      (state_q == S_IDLE),
        .req     (bus.req),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .ptr_nxt (arb_ptr_nxt)
    );

    // tx_clk is a register output in this clock domain, so a single
    // delay stage is enough for edge detection.
    assign tick     = tx_clk & ~tx_clk_q;
    assign bit_end  = tick && (tick_cnt_q == osr_last(osm_q));
    assign in_frame = (state_q == S_START) || (state_q == S_DATA) ||
                      (state_q == S_PARITY) || (state_q == S_STOP);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        data_d     = data_q;
        osm_d      = osm_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        txd_d      = txd_q;
        gnt_d      = '0;
        done_d     = '0;
        busy_d     = busy_q;

        if (in_frame && tick) begin
            tick_cnt_d = bit_end ? '0 : tick_cnt_q + 5'd1;
        end

        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (|arb_gnt) begin
                    gnt_d   = arb_gnt;
                    sel_d   = arb_gnt;
                    osm_d   = osm_sel;
                    busy_d  = 1'b1;
                    ptr_d   = arb_ptr_nxt;
                    state_d = S_ALIGN;
                    for (int i = 0; i < N_REQ; i++) begin
                        if (arb_gnt[i]) begin
                            data_d = bus.data_in[i*DATA_W +: DATA_W];
                        end
                    end
                end
            end
            S_ALIGN: begin
                txd_d = 1'b1;
                if (tick) begin
                    txd_d      = 1'b0;
                    tick_cnt_d = '0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    txd_d     = data_q[0];
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == BW'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
                        txd_d   = ^data_q;
                        state_d = S_PARITY;
`else
                        txd_d   = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        txd_d     = data_q[bit_cnt_q + BW'(1)];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    txd_d   = 1'b1;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                txd_d = 1'b1;
                if (bit_end) begin
                    done_d  = sel_q;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                txd_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge m_clk) begin
        if (!reset) begin
            tx_clk_q   <= 1'b0;
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            sel_q      <= '0;
            data_q     <= '0;
            osm_q      <= 1'b0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            txd_q      <= 1'b1;
            gnt_q      <= '0;
            done_q     <= '0;
            busy_q     <= 1'b0;
        end else begin
            tx_clk_q   <= tx_clk;
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            sel_q      <= sel_d;
            data_q     <= data_d;
            osm_q      <= osm_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            txd_q      <= txd_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;
    assign txd      = txd_q;

endmodule
